fft_sequencer: RTL

- Parametrised successor to the fixed-N FFT control FSM. Sequences a full radix-2 DIT FFT/IFFT job in three phases: bit-reversed LOAD, in-place RUN over log2(N) stages with ping-pong banks, and natural-order READ with a valid/ready handshake.
- Drives the RAM enables and addresses, the bank select, the twiddle ROM address and the even/odd and top/bottom mux selects.
- Compensates for a configurable butterfly pipeline latency, which the previous controller did not handle.

---
 rtl/fft_sequencer.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/fft_sequencer.sv
// fft_sequencer: radix-2 DIT FFT/IFFT job control (bit-reversed load, staged run, read).
// Define FFT_SEQ_SCALE_EN to add o_scale, a per-stage divide-by-2 strobe.
module fft_sequencer #(
  parameter  int N      = 8,
  parameter  int BF_LAT = 2,
  localparam int S      = $clog2(N),
  localparam int AW     = S,
  localparam int SW     = (S > 1) ? $clog2(S) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          i_start,
  input  logic          i_inverse,
  input  logic          i_load_valid,
  output logic          o_load_ready,
  output logic [AW-1:0] o_load_addr,
  output logic          o_rd_en,
  output logic [AW-1:0] o_rd_addr,
  output logic          o_rd_sel_odd,
  output logic          o_wr_en,
  output logic [AW-1:0] o_wr_addr,
  output logic          o_wr_sel_bot,
  output logic          o_bank,
  output logic [AW-2:0] o_twi_addr,
  output logic          o_twi_conj,
  output logic [SW-1:0] o_stage,
  output logic          o_read_valid,
  input  logic          i_read_ready,
  output logic [AW-1:0] o_read_addr,
  output logic          o_busy,
  output logic          o_done
`ifdef FFT_SEQ_SCALE_EN
  ,
  output logic          o_scale
`endif
);

  localparam int CW = $clog2(N + BF_LAT);

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    RUN,
    READ,
    DONE
  } state_t;

  state_t state, state_nx;

  logic [AW-1:0] lcnt;
  logic [AW-1:0] rcnt;
  logic [CW-1:0] cyc;
  logic [SW-1:0] stage;
  logic          inv;

  logic load_last;
  logic stage_last;
  logic run_last;
  logic read_last;

  assign load_last  = i_load_valid && (lcnt == AW'(N - 1));
  assign stage_last = (cyc == CW'(N + BF_LAT - 1));
  assign run_last   = stage_last && (stage == SW'(S - 1));
  assign read_last  = i_read_ready && (rcnt == AW'(N - 1));

  function automatic logic [AW-1:0] bitrev(input logic [AW-1:0] v);
    logic [AW-1:0] r;
    for (int i = 0; i < AW; i++) r[i] = v[AW-1-i];
    return r;
  endfunction

  // Butterfly pair addressing for the current read cycle
  logic          rd_on;
  logic [AW-2:0] pair;
  logic [AW-2:0] mask;
  logic [AW-2:0] lo;
  logic [AW-1:0] top;
  logic [AW-1:0] rd_addr;
  logic [AW-2:0] twi;

  assign rd_on = (state == RUN) && (cyc < CW'(N));
  assign pair  = cyc[AW-1:1];

  always_comb begin
    mask    = ((AW-1)'(1) << stage) - (AW-1)'(1);
    lo      = pair & mask;
    top     = ((({1'b0, pair} >> stage) << stage) << 1) | {1'b0, lo};
    rd_addr = cyc[0] ? (top | (AW'(1) << stage)) : top;
    twi     = lo << (SW'(S - 1) - stage);
  end

  // Write side replays the read stream BF_LAT cycles later
  logic [BF_LAT-1:0] pv;
  logic [BF_LAT-1:0] ps;
  logic [AW-1:0]     pa [BF_LAT];

  always_ff @(posedge clk) begin
    if (!rst) begin
      pv <= '0;
      ps <= '0;
      for (int k = 0; k < BF_LAT; k++) pa[k] <= '0;
    end else begin
      pv[0] <= rd_on;
      ps[0] <= cyc[0];
      pa[0] <= rd_addr;
      for (int k = 1; k < BF_LAT; k++) begin
        pv[k] <= pv[k-1];
        ps[k] <= ps[k-1];
        pa[k] <= pa[k-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      lcnt  <= '0;
      rcnt  <= '0;
      cyc   <= '0;
      stage <= '0;
      inv   <= 1'b0;
    end else begin
      if (state == IDLE && i_start)
        inv <= i_inverse;
      if (state == LOAD && i_load_valid)
        lcnt <= load_last ? '0 : lcnt + 1'b1;
      if (state == RUN) begin
        cyc <= stage_last ? '0 : cyc + 1'b1;
        if (stage_last)
          stage <= run_last ? '0 : stage + 1'b1;
      end
      if (state == READ && i_read_ready)
        rcnt <= read_last ? '0 : rcnt + 1'b1;
    end
  end

  always_comb begin
    state_nx     = state;
    o_load_ready = 1'b0;
    o_load_addr  = '0;
    o_rd_en      = 1'b0;
    o_rd_addr    = '0;
    o_rd_sel_odd = 1'b0;
    o_wr_en      = 1'b0;
    o_wr_addr    = '0;
    o_wr_sel_bot = 1'b0;
    o_bank       = 1'b0;
    o_twi_addr   = '0;
    o_twi_conj   = 1'b0;
    o_stage      = '0;
    o_read_valid = 1'b0;
    o_read_addr  = '0;
    o_busy       = 1'b0;
    o_done       = 1'b0;
    // Outputs are gated by rst so an abort drops every strobe at once
    if (rst) begin
      o_twi_conj = inv;
      unique case (state)
        IDLE: begin
          if (i_start) state_nx = LOAD;
        end
        LOAD: begin
          o_busy       = 1'b1;
          o_load_ready = 1'b1;
          o_load_addr  = bitrev(lcnt);
          if (load_last) state_nx = RUN;
        end
        RUN: begin
          o_busy       = 1'b1;
          o_bank       = stage[0];
          o_stage      = stage;
          o_rd_en      = rd_on;
          o_rd_addr    = rd_on ? rd_addr : '0;
          o_rd_sel_odd = rd_on & cyc[0];
          o_twi_addr   = rd_on ? twi : '0;
          o_wr_en      = pv[BF_LAT-1];
          o_wr_addr    = pv[BF_LAT-1] ? pa[BF_LAT-1] : '0;
          o_wr_sel_bot = pv[BF_LAT-1] & ps[BF_LAT-1];
          if (run_last) state_nx = READ;
        end
        READ: begin
          o_busy       = 1'b1;
          o_bank       = ((S % 2) == 1);
          o_read_valid = 1'b1;
          o_read_addr  = rcnt;
          if (read_last) state_nx = DONE;
        end
        DONE: begin
          o_busy   = 1'b1;
          o_done   = 1'b1;
          state_nx = IDLE;
        end
        default: state_nx = IDLE;
      endcase
    end
  end

`ifdef FFT_SEQ_SCALE_EN
  assign o_scale = o_wr_en;
`endif

endmodule
